loa_add_arbiter: RTL and testbench

LOA_ADD_ARBITER -- requirements
Module: loa_add_arbiter

---
 rtl/loa_add_arbiter.sv | 105 ++++++++++
 tb/tb_loa_add_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/loa_add_arbiter.sv
// Four-requester round-robin front end feeding a single-slot 32-bit adder.
// Define LOA_APPROX_EN to use the lower-part-OR approximate adder.
module loa_add_arbiter #(
  parameter int APX_BITS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_valid,
  output logic [3:0]   req_ready,
  input  logic [127:0] req_a,
  input  logic [127:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [1:0]   rsp_id,
  output logic [31:0]  rsp_sum,
  output logic         rsp_cout
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t      r_state;
  logic [1:0]  r_ptr;
  logic [1:0]  r_id;
  logic [31:0] r_sum;
  logic        r_cout;

  logic [1:0]  w_win;
  logic [1:0]  w_idx;
  logic        w_any;
  logic        w_open;
  logic        w_req_xfer;
  logic        w_rsp_xfer;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [32:0] w_res;

  // Walk from ptr+3 down to ptr so the nearest valid requester wins.
  always_comb begin
    w_win = r_ptr;
    w_any = 1'b0;
    w_idx = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (req_valid[w_idx]) begin
        w_win = w_idx;
        w_any = 1'b1;
      end
    end
  end

  assign w_open     = !rst && ((r_state == S_EMPTY) || rsp_ready);
  assign w_req_xfer = w_open && w_any;
  assign w_rsp_xfer = (r_state == S_FULL) && rsp_ready;

  always_comb begin
    req_ready = 4'b0000;
    if (w_req_xfer) req_ready[w_win] = 1'b1;
  end

  assign w_a = req_a[{w_win, 5'd0} +: 32];
  assign w_b = req_b[{w_win, 5'd0} +: 32];

`ifdef LOA_APPROX_EN
  logic [APX_BITS-1:0] w_lo;
  logic                w_cin;
  logic [32-APX_BITS:0] w_hi;

  // Lower bits are OR'd; only their top bit pair generates a carry.
  assign w_lo  = w_a[APX_BITS-1:0] | w_b[APX_BITS-1:0];
  assign w_cin = w_a[APX_BITS-1] & w_b[APX_BITS-1];
  assign w_hi  = {1'b0, w_a[31:APX_BITS]}
               + {1'b0, w_b[31:APX_BITS]}
               + {{(32-APX_BITS){1'b0}}, w_cin};
  assign w_res = {w_hi, w_lo};
`else
  assign w_res = {1'b0, w_a} + {1'b0, w_b};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_ptr   <= 2'd0;
      r_id    <= 2'd0;
      r_sum   <= 32'd0;
      r_cout  <= 1'b0;
    end else if (w_req_xfer) begin
      r_state <= S_FULL;
      r_ptr   <= w_win + 2'd1;
      r_id    <= w_win;
      r_sum   <= w_res[31:0];
      r_cout  <= w_res[32];
    end else if (w_rsp_xfer) begin
      r_state <= S_EMPTY;
    end
  end

  assign rsp_valid = (r_state == S_FULL);
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;

endmodule

// File: tb/tb_loa_add_arbiter.sv
// Directed bench for loa_add_arbiter with a cycle-level reference model.
// Works for both the exact and LOA_APPROX_EN builds.
module tb_loa_add_arbiter;
  localparam int APX = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_sum;
  logic         rsp_cout;

  int n_vec = 0;
  int n_err = 0;

  bit          m_init = 0;
  bit          m_full;
  int          m_ptr;
  int          m_id;
  logic [32:0] m_res;

  always #5 clk = ~clk;

  loa_add_arbiter #(.APX_BITS(APX)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] ref_add(logic [31:0] a, logic [31:0] b);
    longint unsigned la, lb, lo, hi, c, mask;
    la = a;
    lb = b;
`ifdef LOA_APPROX_EN
    mask = (64'd1 << APX) - 1;
    lo   = (la | lb) & mask;
    c    = (la >> (APX - 1)) & (lb >> (APX - 1)) & 1;
    hi   = (la >> APX) + (lb >> APX) + c;
    return 33'((hi << APX) | lo);
`else
    mask = 0;
    lo   = 0;
    c    = 0;
    hi   = la + lb;
    return 33'(hi | lo | (c & mask));
`endif
  endfunction

  function automatic int pick(logic [3:0] v, int p, bit open);
    if (!open) return -1;
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // Reference model: one result slot, round-robin pointer.
  always @(posedge clk) begin
    int g;
    if (rst) begin
      m_init = 1;
      m_full = 0;
      m_ptr  = 0;
      m_id   = 0;
      m_res  = '0;
    end else if (m_init) begin
      g = pick(req_valid, m_ptr, !m_full || rsp_ready);
      if (g >= 0) begin
        m_full = 1;
        m_ptr  = (g + 1) % 4;
        m_id   = g;
        m_res  = ref_add(req_a[32*g +: 32], req_b[32*g +: 32]);
      end else if (m_full && rsp_ready) begin
        m_full = 0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [3:0] er;
    if (m_init) begin
      g  = rst ? -1 : pick(req_valid, m_ptr, !m_full || rsp_ready);
      er = (g < 0) ? 4'b0000 : 4'(1 << g);
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_full));
      chk("rsp_id", 64'(rsp_id), 64'(m_id));
      chk("rsp_sum", 64'(rsp_sum), 64'(m_res[31:0]));
      chk("rsp_cout", 64'(rsp_cout), 64'(m_res[32]));
    end
  end

  task automatic setin(logic [3:0] v, logic rr);
    req_valid = v;
    rsp_ready = rr;
  endtask

  task automatic setop(int i, logic [31:0] a, logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic next;
    @(posedge clk);
    #2;
  endtask

  task automatic mid;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    setin(4'b0000, 1'b0);
    req_a = '0;
    req_b = '0;
    next;
    setin(4'b1111, 1'b1);
    next;
    mid;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_valid", 64'(rsp_valid), 64'h0);
    chk("rst_sum", 64'(rsp_sum), 64'h0);

    // All requesters held valid: grants rotate 0,1,2,3,...
    for (int i = 0; i < 4; i++)
      setop(i, 32'h11111111 * i, 32'h01010101 * (i + 1));
    next;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      mid;
      chk("rr_grant", 64'(req_ready), 64'(1 << (k % 4)));
      if (k > 0) chk("rr_id", 64'(rsp_id), 64'((k - 1) % 4));
      next;
    end

    // Carry-out case from requester 2.
    setop(2, 32'hFFFFFFFF, 32'h00000001);
    setin(4'b0100, 1'b1);
    mid;
    chk("c_grant", 64'(req_ready), 64'h4);
    next;
    setin(4'b0000, 1'b1);
    mid;
    chk("c_id", 64'(rsp_id), 64'h2);
`ifdef LOA_APPROX_EN
    chk("c_sum", 64'(rsp_sum), 64'hFFFFFFFF);
    chk("c_cout", 64'(rsp_cout), 64'h0);
`else
    chk("c_sum", 64'(rsp_sum), 64'h0);
    chk("c_cout", 64'(rsp_cout), 64'h1);
`endif

    // Approximate vs exact lower part, requester 1 (ptr wraps 3->1).
    next;
    setop(1, 32'h000000FF, 32'h00000081);
    setin(4'b0010, 1'b1);
    mid;
    chk("a_grant", 64'(req_ready), 64'h2);
    next;
    setin(4'b0000, 1'b0);
    mid;
    chk("a_id", 64'(rsp_id), 64'h1);
`ifdef LOA_APPROX_EN
    chk("a_sum", 64'(rsp_sum), 64'h1FF);
`else
    chk("a_sum", 64'(rsp_sum), 64'h180);
`endif
    chk("a_cout", 64'(rsp_cout), 64'h0);

    // Backpressure: result held, no grants.
    repeat (5) begin
      next;
      setin(4'b0001, 1'b0);
      mid;
      chk("bp_ready", 64'(req_ready), 64'h0);
      chk("bp_id", 64'(rsp_id), 64'h1);
      chk("bp_valid", 64'(rsp_valid), 64'h1);
    end
    next;
    setop(0, 32'h12345678, 32'h11111111);
    setin(4'b0001, 1'b1);
    mid;
    chk("bp_refill", 64'(req_ready), 64'h1);
    next;
    setin(4'b0000, 1'b0);
    mid;
    chk("bp_new_id", 64'(rsp_id), 64'h0);
`ifdef LOA_APPROX_EN
    chk("bp_new_sum", 64'(rsp_sum), 64'h23456779);
`else
    chk("bp_new_sum", 64'(rsp_sum), 64'h23456789);
`endif

    // Reset while FULL and stalled.
    rst = 1'b1;
    next;
    rst = 1'b0;
    setin(4'b1010, 1'b1);
    mid;
    chk("mr_valid", 64'(rsp_valid), 64'h0);
    chk("mr_grant", 64'(req_ready), 64'h2);
    next;

    // ptr=2 with 0101: 2 wins, then 0 wins after wrap.
    setop(2, 32'h80000000, 32'h80000000);
    setop(0, 32'h00000F0F, 32'h000000F1);
    setin(4'b0101, 1'b1);
    mid;
    chk("w_grant2", 64'(req_ready), 64'h4);
    chk("w_id1", 64'(rsp_id), 64'h1);
    next;
    mid;
    chk("w_grant0", 64'(req_ready), 64'h1);
    chk("w_cout", 64'(rsp_cout), 64'h1);
    next;
    setin(4'b0000, 1'b1);
    mid;
    chk("w_id0", 64'(rsp_id), 64'h0);
    next;
    next;
    mid;
    chk("end_valid", 64'(rsp_valid), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
